// File: rtl/mpls_label_xlate.sv
// Three-stage MPLS incoming-label translator: label -> descriptor address plus two counter
// addresses, with per-delivery label-space / descriptor-window error pulses.
module mpls_label_xlate #(
  parameter int unsigned LABEL_WIDTH = 20,
  parameter int unsigned ADDR_WIDTH  = 19
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_vld,
  output logic                   in_rdy,
  input  logic [LABEL_WIDTH-1:0] in_label,
  input  logic [1:0]             in_port,
  input  logic [ADDR_WIDTH-1:0]  ls1_base,
  input  logic [ADDR_WIDTH-1:0]  ls2_base,
  input  logic [ADDR_WIDTH-1:0]  ls3_base,
  input  logic [ADDR_WIDTH-1:0]  ls4_base,
  input  logic [ADDR_WIDTH-1:0]  ls1_bound,
  input  logic [ADDR_WIDTH-1:0]  ls2_bound,
  input  logic [ADDR_WIDTH-1:0]  ls3_bound,
  input  logic [ADDR_WIDTH-1:0]  ls4_bound,
  input  logic [ADDR_WIDTH-1:0]  ld_base,
  input  logic [ADDR_WIDTH-1:0]  ld_bound,
  input  logic [ADDR_WIDTH-1:0]  counter1_base,
  input  logic [ADDR_WIDTH-1:0]  counter2_base,
  output logic                   out_vld,
  input  logic                   out_rdy,
  output logic [ADDR_WIDTH-1:0]  out_ld_addr,
  output logic [ADDR_WIDTH-1:0]  out_cnt1_addr,
  output logic [ADDR_WIDTH-1:0]  out_cnt2_addr,
  output logic                   out_miss,
  output logic                   label_space_error,
  output logic                   drop_ld_error
);

  localparam int unsigned SumW = LABEL_WIDTH + 1;

  typedef logic [ADDR_WIDTH-1:0]  addr_t;
  typedef logic [LABEL_WIDTH-1:0] label_t;
  typedef logic [SumW-1:0]        sum_t;

  logic   w_adv;
  addr_t  w_sel_base, w_sel_bound;
  logic   w_ls_ok;
  label_t w_offset;
  sum_t   w_sum;
  logic   w_ld_ok;
  addr_t  w_cnt1, w_cnt2;

  // S1: accepted request plus config snapshot
  logic   r_s1_vld;
  label_t r_s1_label;
  addr_t  r_s1_base, r_s1_bound, r_s1_ld_base, r_s1_ld_bound, r_s1_cnt1_base, r_s1_cnt2_base;

  // S2: range check result
  logic   r_s2_vld, r_s2_ls_ok;
  label_t r_s2_offset;
  addr_t  r_s2_ld_base, r_s2_ld_bound, r_s2_cnt1_base, r_s2_cnt2_base;

  // S3: final, already-masked result
  logic   r_s3_vld, r_s3_miss, r_s3_ls_err, r_s3_ld_err;
  addr_t  r_s3_ld_addr, r_s3_cnt1, r_s3_cnt2;

  // Whole pipe advances or freezes as one; bubbles are not squeezed out.
  assign w_adv  = !r_s3_vld || out_rdy;
  assign in_rdy = w_adv;

  always_comb begin
    w_sel_base  = ls1_base;
    w_sel_bound = ls1_bound;
    unique case (in_port)
      2'd0: begin w_sel_base = ls1_base; w_sel_bound = ls1_bound; end
      2'd1: begin w_sel_base = ls2_base; w_sel_bound = ls2_bound; end
      2'd2: begin w_sel_base = ls3_base; w_sel_bound = ls3_bound; end
      2'd3: begin w_sel_base = ls4_base; w_sel_bound = ls4_bound; end
      default: ;
    endcase
  end

  assign w_ls_ok  = (r_s1_label >= label_t'(r_s1_base)) && (r_s1_label <= label_t'(r_s1_bound));
  assign w_offset = r_s1_label - label_t'(r_s1_base);

  assign w_sum   = sum_t'(r_s2_ld_base) + sum_t'(r_s2_offset);
  assign w_ld_ok = r_s2_ls_ok && (w_sum <= sum_t'(r_s2_ld_bound));
  assign w_cnt1  = r_s2_cnt1_base + r_s2_offset[ADDR_WIDTH-1:0];
  assign w_cnt2  = r_s2_cnt2_base + r_s2_offset[ADDR_WIDTH-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_vld       <= 1'b0;
      r_s1_label     <= '0;
      r_s1_base      <= '0;
      r_s1_bound     <= '0;
      r_s1_ld_base   <= '0;
      r_s1_ld_bound  <= '0;
      r_s1_cnt1_base <= '0;
      r_s1_cnt2_base <= '0;
      r_s2_vld       <= 1'b0;
      r_s2_ls_ok     <= 1'b0;
      r_s2_offset    <= '0;
      r_s2_ld_base   <= '0;
      r_s2_ld_bound  <= '0;
      r_s2_cnt1_base <= '0;
      r_s2_cnt2_base <= '0;
      r_s3_vld       <= 1'b0;
      r_s3_miss      <= 1'b0;
      r_s3_ls_err    <= 1'b0;
      r_s3_ld_err    <= 1'b0;
      r_s3_ld_addr   <= '0;
      r_s3_cnt1      <= '0;
      r_s3_cnt2      <= '0;
    end else if (w_adv) begin
      r_s1_vld <= in_vld;
      r_s2_vld <= r_s1_vld;
      r_s3_vld <= r_s2_vld;
      if (in_vld) begin
        r_s1_label     <= in_label;
        r_s1_base      <= w_sel_base;
        r_s1_bound     <= w_sel_bound;
        r_s1_ld_base   <= ld_base;
        r_s1_ld_bound  <= ld_bound;
        r_s1_cnt1_base <= counter1_base;
        r_s1_cnt2_base <= counter2_base;
      end
      if (r_s1_vld) begin
        r_s2_ls_ok     <= w_ls_ok;
        r_s2_offset    <= w_offset;
        r_s2_ld_base   <= r_s1_ld_base;
        r_s2_ld_bound  <= r_s1_ld_bound;
        r_s2_cnt1_base <= r_s1_cnt1_base;
        r_s2_cnt2_base <= r_s1_cnt2_base;
      end
      if (r_s2_vld) begin
        r_s3_miss    <= !w_ld_ok;
        r_s3_ls_err  <= !r_s2_ls_ok;
        r_s3_ld_err  <= r_s2_ls_ok && !w_ld_ok;
        r_s3_ld_addr <= w_ld_ok ? w_sum[ADDR_WIDTH-1:0] : '0;
        r_s3_cnt1    <= w_ld_ok ? w_cnt1 : '0;
        r_s3_cnt2    <= w_ld_ok ? w_cnt2 : '0;
      end
    end
  end

  assign out_vld       = r_s3_vld;
  assign out_ld_addr   = r_s3_ld_addr;
  assign out_cnt1_addr = r_s3_cnt1;
  assign out_cnt2_addr = r_s3_cnt2;
  assign out_miss      = r_s3_miss;

  // Pulses only on the transfer cycle, so a held result reports once.
  assign label_space_error = r_s3_vld && out_rdy && r_s3_ls_err;
  assign drop_ld_error     = r_s3_vld && out_rdy && r_s3_ld_err;

endmodule

// File: tb/tb_mpls_label_xlate.sv
// Bench for mpls_label_xlate: directed vector table, hand-written stall/reset sequences and a
// randomized run checked by a scoreboard against a plain arithmetic reference model.
module tb_mpls_label_xlate;

  typedef struct packed {
    logic        miss;
    logic        lse;
    logic        lde;
    logic [18:0] ld;
    logic [18:0] c1;
    logic [18:0] c2;
  } res_t;

  typedef struct {
    res_t r;
    int   acc;
  } sb_t;

  typedef struct {
    logic [19:0] label;
    logic [1:0]  port;
    res_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_vld = 1'b0;
  logic        in_rdy;
  logic [19:0] in_label = '0;
  logic [1:0]  in_port = '0;
  logic [18:0] ls_base [4];
  logic [18:0] ls_bound [4];
  logic [18:0] ld_base, ld_bound, cnt1_base, cnt2_base;
  logic        out_vld;
  logic        out_rdy = 1'b0;
  logic [18:0] out_ld_addr, out_cnt1_addr, out_cnt2_addr;
  logic        out_miss, label_space_error, drop_ld_error;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  sb_t  sb[$];
  vec_t tbl [10];

  mpls_label_xlate #(.LABEL_WIDTH(20), .ADDR_WIDTH(19)) dut (
    .clk               (clk),
    .reset             (reset),
    .in_vld            (in_vld),
    .in_rdy            (in_rdy),
    .in_label          (in_label),
    .in_port           (in_port),
    .ls1_base          (ls_base[0]),
    .ls2_base          (ls_base[1]),
    .ls3_base          (ls_base[2]),
    .ls4_base          (ls_base[3]),
    .ls1_bound         (ls_bound[0]),
    .ls2_bound         (ls_bound[1]),
    .ls3_bound         (ls_bound[2]),
    .ls4_bound         (ls_bound[3]),
    .ld_base           (ld_base),
    .ld_bound          (ld_bound),
    .counter1_base     (cnt1_base),
    .counter2_base     (cnt2_base),
    .out_vld           (out_vld),
    .out_rdy           (out_rdy),
    .out_ld_addr       (out_ld_addr),
    .out_cnt1_addr     (out_cnt1_addr),
    .out_cnt2_addr     (out_cnt2_addr),
    .out_miss          (out_miss),
    .label_space_error (label_space_error),
    .drop_ld_error     (drop_ld_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic res_t got();
    return '{miss: out_miss, lse: label_space_error, lde: drop_ld_error,
             ld: out_ld_addr, c1: out_cnt1_addr, c2: out_cnt2_addr};
  endfunction

  function automatic res_t mk(input logic m, input logic lse, input logic lde,
                              input logic [18:0] ld, input logic [18:0] c1, input logic [18:0] c2);
    return '{miss: m, lse: lse, lde: lde, ld: ld, c1: c1, c2: c2};
  endfunction

  // Reference: label space check, then descriptor window check, counters wrap mod 2^19.
  function automatic res_t model(input logic [19:0] lab, input logic [18:0] b, input logic [18:0] bd,
                                 input logic [18:0] ldb, input logic [18:0] ldbd,
                                 input logic [18:0] c1, input logic [18:0] c2);
    longint l = longint'(lab);
    longint off, sum;
    res_t r = '0;
    if (l < longint'(b) || l > longint'(bd)) begin
      r.miss = 1'b1;
      r.lse  = 1'b1;
    end else begin
      off = l - longint'(b);
      sum = longint'(ldb) + off;
      if (sum > longint'(ldbd)) begin
        r.miss = 1'b1;
        r.lde  = 1'b1;
      end else begin
        r.ld = 19'(sum);
        r.c1 = 19'((longint'(c1) + off) % 64'h80000);
        r.c2 = 19'((longint'(c2) + off) % 64'h80000);
      end
    end
    return r;
  endfunction

  // Scoreboard: every delivery must match the oldest accepted request.
  always @(negedge clk) begin
    sb_t e;
    if (!reset) begin
      sb.delete();
      chk("reset_quiet", {61'b0, out_vld, label_space_error, drop_ld_error}, 64'd0);
    end else begin
      if (out_vld && out_rdy) begin
        if (sb.size() == 0) chk("unexpected_result", {63'b0, out_vld}, 64'd0);
        else begin
          e = sb.pop_front();
          chk("sb_result", 64'(got()), 64'(e.r));
        end
      end else begin
        chk("no_pulse_idle", {62'b0, label_space_error, drop_ld_error}, 64'd0);
      end
      if (in_vld && in_rdy) begin
        e.r = model(in_label, ls_base[in_port], ls_bound[in_port], ld_base, ld_bound,
                    cnt1_base, cnt2_base);
        e.acc = cyc;
        sb.push_back(e);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [19:0] l, input logic [1:0] p, output int acc);
    bit ok = 0;
    in_vld   = 1'b1;
    in_label = l;
    in_port  = p;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (in_rdy) ok = 1;
    end
    if (!ok) chk("accept_timeout", {63'b0, in_rdy}, 64'd1);
    acc = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_result(input string nm, input int acc, input res_t exp);
    bit seen = 0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clk);
      if (out_vld) seen = 1;
    end
    if (!seen) chk({nm, "_timeout"}, {63'b0, out_vld}, 64'd1);
    else begin
      chk({nm, "_latency"}, 64'(cyc - acc), 64'd3);
      chk({nm, "_result"}, 64'(got()), 64'(exp));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    int acc;
    send(v.label, v.port, acc);
    in_vld = 1'b0;
    wait_result(nm, acc, v.exp);
  endtask

  task automatic base_cfg();
    ls_base[0] = 19'd100;     ls_bound[0] = 19'd199;
    ls_base[1] = 19'd0;       ls_bound[1] = 19'h7FFFF;
    ls_base[2] = 19'h7FF00;   ls_bound[2] = 19'h7FFFF;
    ls_base[3] = 19'd500;     ls_bound[3] = 19'd400;
    ld_base    = 19'h1000;    ld_bound    = 19'h10FF;
    cnt1_base  = 19'h2000;    cnt2_base   = 19'h3000;
  endtask

  task automatic rand_cfg();
    int unsigned b, len;
    for (int s = 0; s < 4; s++) begin
      b   = $urandom_range(0, 32'h7FFFF);
      len = $urandom_range(0, 512);
      ls_base[s] = 19'(b);
      if ($urandom_range(0, 5) == 0) ls_bound[s] = (b > 0) ? 19'(b - 1) : 19'd0;
      else ls_bound[s] = (b + len > 32'h7FFFF) ? 19'h7FFFF : 19'(b + len);
    end
    b        = $urandom_range(0, 32'h7FFFF);
    ld_base  = 19'(b);
    len      = $urandom_range(0, 600);
    ld_bound = (b + len > 32'h7FFFF) ? 19'h7FFFF : 19'(b + len);
    cnt1_base = ($urandom_range(0, 1) == 0) ? 19'($urandom_range(32'h7FE00, 32'h7FFFF))
                                            : 19'($urandom);
    cnt2_base = 19'($urandom);
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout want finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, a0, nd, nl, first, last;
    base_cfg();

    tbl[0] = '{20'd150,     2'd0, mk(0, 0, 0, 19'h1032, 19'h2032, 19'h3032)};
    tbl[1] = '{20'd99,      2'd0, mk(1, 1, 0, 0, 0, 0)};
    tbl[2] = '{20'd100,     2'd0, mk(0, 0, 0, 19'h1000, 19'h2000, 19'h3000)};
    tbl[3] = '{20'd199,     2'd0, mk(0, 0, 0, 19'h1063, 19'h2063, 19'h3063)};
    tbl[4] = '{20'd200,     2'd0, mk(1, 1, 0, 0, 0, 0)};
    tbl[5] = '{20'hFFFFF,   2'd1, mk(1, 1, 0, 0, 0, 0)};
    tbl[6] = '{20'h000FF,   2'd1, mk(0, 0, 0, 19'h10FF, 19'h20FF, 19'h30FF)};
    tbl[7] = '{20'h00100,   2'd1, mk(1, 0, 1, 0, 0, 0)};
    tbl[8] = '{20'h7FF10,   2'd2, mk(0, 0, 0, 19'h1010, 19'h2010, 19'h3010)};
    tbl[9] = '{20'd450,     2'd3, mk(1, 1, 0, 0, 0, 0)};

    repeat (3) @(negedge clk);
    chk("reset_in_rdy", {63'b0, in_rdy}, 64'd1);
    chk("reset_outputs", {3'b0, out_vld, out_miss, label_space_error, drop_ld_error,
                          out_ld_addr, out_cnt1_addr, out_cnt2_addr}, 64'd0);
    @(posedge clk);
    #1;
    reset   = 1'b1;
    out_rdy = 1'b1;

    for (int i = 0; i < 10; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

    // Back-to-back 99,100,199,200: four consecutive results, two space errors.
    nd = 0; nl = 0; first = 0; last = 0;
    fork
      begin
        for (int i = 1; i <= 4; i++) send(tbl[i].label, tbl[i].port, acc);
        in_vld = 1'b0;
      end
      begin
        for (int k = 0; k < 14; k++) begin
          @(negedge clk);
          if (out_vld) begin
            if (nd == 0) first = cyc;
            last = cyc;
            nd++;
          end
          if (label_space_error) nl++;
        end
      end
    join
    chk("b2b_count", 64'(nd), 64'd4);
    chk("b2b_consecutive", 64'(last - first), 64'd3);
    chk("b2b_lse_pulses", 64'(nl), 64'd2);
    @(posedge clk);
    #1;

    // Descriptor window too small.
    ld_bound = 19'h1010;
    run_vec("ld_overflow", '{20'd150, 2'd0, mk(1, 0, 1, 0, 0, 0)});
    ld_bound = 19'h10FF;

    // Five requests with a four-cycle stall while the third sits in S3.
    nd = 0; nl = 0;
    fork
      begin
        send(20'd150, 2'd0, acc);
        send(20'd99,  2'd0, acc);
        send(20'd250, 2'd0, acc);
        send(20'd120, 2'd0, acc);
        send(20'd180, 2'd0, acc);
        in_vld = 1'b0;
      end
      begin
        int n = 0;
        for (int k = 0; k < 30 && n < 2; k++) begin
          @(negedge clk);
          if (out_vld) n++;
        end
        @(posedge clk);
        #1 out_rdy = 1'b0;
        repeat (4) begin
          @(negedge clk);
          chk("stall_in_rdy", {63'b0, in_rdy}, 64'd0);
          chk("stall_hold_vld", {63'b0, out_vld}, 64'd1);
        end
        @(posedge clk);
        #1 out_rdy = 1'b1;
      end
      begin
        for (int k = 0; k < 30; k++) begin
          @(negedge clk);
          if (out_vld && out_rdy) nd++;
          if (label_space_error) nl++;
        end
      end
    join
    chk("stall_deliveries", 64'(nd), 64'd5);
    chk("stall_lse_pulses", 64'(nl), 64'd2);
    @(posedge clk);
    #1;

    // Empty space 4 (500>400); widening it after acceptance must not rescue the request.
    send(20'd450, 2'd3, a0);
    in_vld = 1'b0;
    @(posedge clk);
    #1;
    ls_base[3] = 19'd400; ls_bound[3] = 19'd500;
    wait_result("ls4_inflight", a0, mk(1, 1, 0, 0, 0, 0));
    run_vec("ls4_new", '{20'd450, 2'd3, mk(0, 0, 0, 19'h1032, 19'h2032, 19'h3032)});
    ls_base[3] = 19'd500; ls_bound[3] = 19'd400;

    // Reset with three requests in flight.
    out_rdy = 1'b0;
    for (int i = 0; i < 3; i++) send(20'd99, 2'd0, acc);
    in_vld = 1'b0;
    chk("pre_reset_vld", {63'b0, out_vld}, 64'd1);
    chk("pre_reset_in_rdy", {63'b0, in_rdy}, 64'd0);
    #2 reset = 1'b0;
    #1 chk("reset_drop_vld", {63'b0, out_vld}, 64'd0);
    out_rdy = 1'b1;
    #1 chk("reset_no_pulse", {62'b0, label_space_error, drop_ld_error}, 64'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    run_vec("post_reset", tbl[0]);

    // Randomized traffic, checked by the scoreboard.
    for (int i = 0; i < 400; i++) begin
      if (i % 25 == 0) rand_cfg();
      in_vld  = ($urandom_range(0, 3) != 0);
      in_port = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) in_label = 20'($urandom);
      else in_label = 20'(32'(ls_base[in_port]) + $urandom_range(0, 520) - 32'd4);
      out_rdy = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    in_vld  = 1'b0;
    out_rdy = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("drain_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
